// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle mult/div/madd sequencer owning HI/LO, with mf*/mt* access and MD stall request.
module md_sequencer #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             madd,
  input  logic             hilo,
  input  logic             we,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  input  logic             md_use_d,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] rd_data
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
  logic [1:0]         r_op;
  logic               r_madd;
  logic               w_launch, w_commit, w_mt, w_last;
  logic [2*WIDTH-1:0] w_ea, w_eb, w_prod, w_acc, w_res;
  logic               w_neg_a, w_neg_b;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_dvs, w_q, w_r, w_div_hi, w_div_lo;
  assign w_last   = r_cnt == CW'(1);
  assign w_launch = r_state == IDLE && start && !flush;
  assign w_commit = r_state != IDLE && w_last && !flush;
  assign w_mt     = r_state == IDLE && we && !start && !flush;
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_comb begin
    w_next = flush ? IDLE :
             r_state == IDLE ? (start ? (op[1] ? DIV : MUL) : IDLE) :
             w_last ? IDLE : r_state;
  end
  always_comb begin
    busy      = r_state != IDLE;
    stall_req = md_use_d & (busy | start);
    rd_data   = hilo ? r_lo : r_hi;
  end
  // op[0] selects signed extension for the double-width multiply
  assign w_ea   = {{WIDTH{r_op[0] & r_a[WIDTH-1]}}, r_a};
  assign w_eb   = {{WIDTH{r_op[0] & r_b[WIDTH-1]}}, r_b};
  assign w_prod = w_ea * w_eb;
  assign w_acc  = {r_hi, r_lo} + w_prod;
  // signed divide via magnitudes; quotient truncates toward zero, remainder takes dividend sign
  assign w_neg_a  = r_op[0] & r_a[WIDTH-1];
  assign w_neg_b  = r_op[0] & r_b[WIDTH-1];
  assign w_abs_a  = w_neg_a ? -r_a : r_a;
  assign w_abs_b  = w_neg_b ? -r_b : r_b;
  assign w_dvs    = w_abs_b == '0 ? WIDTH'(1) : w_abs_b;
  assign w_q      = w_abs_a / w_dvs;
  assign w_r      = w_abs_a % w_dvs;
  assign w_div_lo = r_b == '0 ? '1 : (w_neg_a ^ w_neg_b) ? -w_q : w_q;
  assign w_div_hi = r_b == '0 ? r_a : w_neg_a ? -w_r : w_r;
  assign w_res    = r_op[1] ? {w_div_hi, w_div_lo} : r_madd ? w_acc : w_prod;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_madd <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      if (flush) r_cnt <= '0;
      else if (w_launch) r_cnt <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      else if (r_state != IDLE) r_cnt <= r_cnt - CW'(1);
      if (w_launch) begin
        r_a    <= rs_data;
        r_b    <= rt_data;
        r_op   <= op;
        r_madd <= madd;
      end
      if (w_commit) {r_hi, r_lo} <= w_res;
      else if (w_mt && hilo) r_lo <= rs_data;
      else if (w_mt) r_hi <= rs_data;
    end
  end
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: randomized + directed scoreboard bench for md_sequencer against an arithmetic reference model.
module tb_md_sequencer;
  localparam int MUL_C = 5;
  localparam int DIV_C = 10;
  localparam int NORM = 0, INTF = 1, FLSH = 2, RST = 3, WEL = 4;
  typedef struct {int len; logic [31:0] hi; logic [31:0] lo;} item_t;
  logic        clk = 0, reset = 0, start = 0, madd = 0, hilo = 0, we = 0, flush = 0, md_use_d = 0;
  logic [1:0]  op = 0;
  logic [31:0] rs_data = 0, rt_data = 0;
  logic        busy, stall_req;
  logic [31:0] rd_data;
  int          checks = 0, errors = 0;
  item_t       q[$];
  item_t       cur;
  logic [31:0] m_hi = 0, m_lo = 0;
  int          run_len = 0;
  bit          pend = 0;
  md_sequencer #(.WIDTH(32), .MULT_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .madd(madd), .hilo(hilo), .we(we),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .md_use_d(md_use_d),
    .busy(busy), .stall_req(stall_req), .rd_data(rd_data));
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] model(input logic [1:0] o, input logic md, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int sa, sb;
    if (o[1]) begin
      if (b == 0) return {a, 32'hFFFFFFFF};
      if (!o[0]) return {a % b, a / b};
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, a};
      sa = a;
      sb = b;
      return {32'(sa % sb), 32'(sa / sb)};
    end
    p = o[0] ? longint'($signed(a)) * longint'($signed(b)) : longint'({32'b0, a}) * longint'({32'b0, b});
    return md ? {m_hi, m_lo} + 64'(p) : 64'(p);
  endfunction
  // monitor: measures each busy run and checks HI then LO in the two idle cycles after it
  always @(negedge clk) begin
    if (busy) begin
      run_len++;
      if (run_len > 64) begin
        check("busy_timeout", 32'(run_len), 32'd64);
        run_len = 0;
      end
    end else if (pend) begin
      check("rd_second", rd_data, hilo ? cur.lo : cur.hi);
      pend = 0;
    end else if (run_len > 0) begin
      if (q.size() == 0) check("unexpected_op", 32'(run_len), 32'd0);
      else begin
        cur = q.pop_front();
        check("busy_len", 32'(run_len), 32'(cur.len));
        check("rd_first", rd_data, hilo ? cur.lo : cur.hi);
        pend = 1;
      end
      run_len = 0;
    end
  end
  task automatic run(input logic [1:0] o, input logic md, input logic [31:0] a, input logic [31:0] b,
                     input int kind, input int at);
    item_t it;
    logic [63:0] r;
    r = model(o, md, a, b);
    it.len = o[1] ? DIV_C : MUL_C;
    it.hi = r[63:32];
    it.lo = r[31:0];
    if (kind == FLSH) begin it.len = at; it.hi = m_hi; it.lo = m_lo; end
    if (kind == RST) begin it.len = at; it.hi = 0; it.lo = 0; end
    m_hi = it.hi;
    m_lo = it.lo;
    q.push_back(it);
    start = 1; op = o; madd = md; rs_data = a; rt_data = b; hilo = 0;
    we = kind == WEL;
    md_use_d = kind == INTF;
    @(negedge clk);
    if (kind == INTF) check("stall_launch", 32'(stall_req), 32'd1);
    cyc();
    start = 0; we = 0; rs_data = $urandom; rt_data = $urandom;
    for (int i = 1; i <= it.len; i++) begin
      start = kind == INTF && (i == 3 || i == 4);
      we = start;
      if (start) begin op = 2'($urandom); rs_data = $urandom; rt_data = $urandom; end
      flush = kind == FLSH && i == at;
      reset = kind == RST && i == at;
      @(negedge clk);
      if (kind == INTF) check("stall_busy", 32'(stall_req), 32'd1);
      cyc();
    end
    start = 0; we = 0; flush = 0; reset = 0; op = 0; madd = 0;
    md_use_d = kind == RST;
    @(negedge clk);
    if (kind == RST) begin
      check("stall_after_rst", 32'(stall_req), 32'd0);
      check("busy_after_rst", 32'(busy), 32'd0);
    end
    cyc();
    md_use_d = 0;
    hilo = 1;
    cyc();
  endtask
  task automatic mt(input logic sel, input logic [31:0] d);
    we = 1; hilo = sel; rs_data = d;
    cyc();
    we = 0;
    if (sel) m_lo = d; else m_hi = d;
    @(negedge clk);
    check("mt_rd", rd_data, d);
    cyc();
    hilo = !sel;
    @(negedge clk);
    check("mt_other", rd_data, sel ? m_hi : m_lo);
    cyc();
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0] o;
    reset = 1;
    cyc();
    cyc();
    reset = 0;
    md_use_d = 1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_hi", rd_data, 32'd0);
    cyc();
    md_use_d = 0;
    hilo = 1;
    @(negedge clk);
    check("rst_lo", rd_data, 32'd0);
    cyc();
    run(2'b01, 0, 32'hFFFFFFFE, 32'd3, NORM, 0);
    run(2'b00, 0, 32'hFFFFFFFE, 32'd3, NORM, 0);
    mt(0, 32'h1);
    mt(1, 32'hFFFFFFFF);
    run(2'b00, 1, 32'd1, 32'd1, NORM, 0);
    run(2'b11, 0, 32'hFFFFFFF9, 32'd2, NORM, 0);
    run(2'b10, 0, 32'd7, 32'd0, NORM, 0);
    run(2'b11, 0, 32'h80000000, 32'hFFFFFFFF, NORM, 0);
    run(2'b11, 1, 32'd100, 32'hFFFFFFF9, NORM, 0);
    run(2'b11, 0, 32'd1000, 32'd7, INTF, 0);
    run(2'b01, 0, 32'd12345, 32'd678, FLSH, 2);
    run(2'b01, 0, 32'd12345, 32'd678, FLSH, MUL_C);
    run(2'b01, 1, 32'hDEADBEEF, 32'h1234, RST, 3);
    run(2'b01, 0, 32'hFFFFFFFB, 32'd6, NORM, 0);
    run(2'b00, 0, 32'd9, 32'd9, WEL, 0);
    for (int k = 0; k < 40; k++) begin
      o = 2'($urandom);
      case ($urandom_range(0, 9))
        0, 1: mt(1'($urandom), $urandom);
        2: run(o, 1'($urandom), pick(), pick(), FLSH, $urandom_range(1, o[1] ? DIV_C : MUL_C));
        3: run(o, 1'($urandom), pick(), pick(), WEL, 0);
        default: run(o, 1'($urandom), pick(), pick(), NORM, 0);
      endcase
    end
    cyc();
    cyc();
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
